// File: rtl/alu_pkg.sv
// Shared op codes and FSM encodings for the shared-ALU arbiter slice.
// Pure declarations; no logic, so no latency or backpressure.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b1010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/signed-less-than datapath with an illegal-op flag.
// Zero latency, no flow control; the caller registers the outputs.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_err
);

  // Signed compare instead of the sign of a-b, so overflowing operands still order correctly.
  logic w_lt;
  assign w_lt = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_result = '0;
    o_err    = 1'b0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_lt};
      default: o_err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request scanning upward from the pointer, wrapping.
// Purely combinational; holding the grant is the caller's job.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 3
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(i_ptr) + k) % N_REQ;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among N_REQ valid/ready clients; accept -> result valid after two edges.
// One op in flight; requests are not accepted until the held result is taken by res_ready.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = 32,
  parameter int ID_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*4-1:0]     req_op,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic [ID_W-1:0]        res_id,
  output logic                   res_err,
  output logic                   busy
);

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [ID_W-1:0]  r_id;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [ID_W-1:0]  r_res_id;
  logic             r_res_err;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_err;
  logic [ID_W-1:0]  w_ptr_next;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_res),
    .o_err    (w_alu_err)
  );

  assign req_ready  = (r_state == S_IDLE) ? w_grant : '0;
  assign w_ptr_next = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_id        <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A grant implies the transfer: the granted bit is valid by construction.
          if (w_any) begin
            r_a     <= req_a[int'(w_idx)*WIDTH +: WIDTH];
            r_b     <= req_b[int'(w_idx)*WIDTH +: WIDTH];
            r_op    <= req_op[int'(w_idx)*4 +: 4];
            r_id    <= w_idx;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res_data  <= w_alu_res;
          r_res_id    <= r_id;
          r_res_err   <= w_alu_err;
          r_res_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_ptr       <= w_ptr_next;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_err   = r_res_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed corners plus randomized traffic against a
// transaction-level model (round-robin pick, plain-arithmetic results, ordered queue).
module tb_alu_share_arbiter;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int IW = 3;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N*4-1:0]  req_op;
  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_data;
  logic [IW-1:0]   res_id;
  logic            res_err;
  logic            busy;

  logic [W-1:0] a_v  [N];
  logic [W-1:0] b_v  [N];
  logic [3:0]   op_v [N];

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           id;
    int           cyc;
  } txn_t;

  txn_t         q[$];
  int           mptr;
  int           n_done;
  int           cyc;
  int           checks;
  int           failures;
  logic [N-1:0] acc_mask;
  logic         rv_prev;
  logic [W-1:0] last_data;
  int           last_id;
  logic         last_err;

  alu_share_arbiter #(
    .N_REQ (N),
    .WIDTH (W),
    .ID_W  (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_v[i];
      req_b[i*W +: W] = b_v[i];
      req_op[i*4 +: 4] = op_v[i];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference arithmetic: bit 32 is the error flag.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [3:0] op);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'b0000: ref_op = {1'b0, a + b};
      4'b0010: ref_op = {1'b0, a - b};
      4'b1010: ref_op = (sa < sb) ? {1'b0, 32'd1} : {1'b0, 32'd0};
      default: ref_op = {1'b1, 32'd0};
    endcase
  endfunction

  // Transaction-level monitor and scoreboard, sampled on the falling edge.
  initial begin
    logic         qn;
    logic         any;
    int           exp_g;
    int           j;
    logic [N-1:0] exp_rdy;
    logic [W:0]   r;
    txn_t         t;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        mptr     = 0;
        acc_mask = '0;
        rv_prev  = 1'b0;
      end else begin
        qn = (q.size() != 0);
        check_eq("busy", busy, qn);
        any   = 1'b0;
        exp_g = 0;
        if (!qn) begin
          for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (!any && req_valid[j]) begin
              any   = 1'b1;
              exp_g = j;
            end
          end
        end
        exp_rdy = '0;
        if (any) exp_rdy[exp_g] = 1'b1;
        check_eq("req_ready", req_ready, exp_rdy);
        if (res_valid) begin
          if (!qn) check_eq("res_spurious", res_valid, 1'b0);
          else begin
            check_eq("res_data", res_data, q[0].data);
            check_eq("res_id", res_id, q[0].id);
            check_eq("res_err", res_err, q[0].err);
            if (!rv_prev) check_eq("latency", cyc - q[0].cyc, 2);
            if (res_ready) begin
              last_data = q[0].data;
              last_id   = q[0].id;
              last_err  = q[0].err;
              mptr      = (q[0].id + 1) % N;
              void'(q.pop_front());
              n_done++;
            end
          end
        end else if (qn) begin
          check_eq("res_late", (cyc - q[0].cyc) <= 1, 1'b1);
        end
        rv_prev  = res_valid && !res_ready;
        acc_mask = req_valid & req_ready;
        if (any) begin
          r      = ref_op(req_a[exp_g*W +: W], req_b[exp_g*W +: W], req_op[exp_g*4 +: 4]);
          t.data = r[W-1:0];
          t.err  = r[W];
          t.id   = exp_g;
          t.cyc  = cyc;
          q.push_back(t);
        end
      end
    end
  end

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (n_done < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, n_done >= target, 1'b1);
  endtask

  task automatic wait_acc(input int i, input string tag);
    int n;
    n = 0;
    while (!acc_mask[i] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, acc_mask[i], 1'b1);
  endtask

  task automatic wait_resp_valid(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, res_valid, 1'b1);
  endtask

  task automatic settle();
    int n;
    n = 0;
    res_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op);
    int base;
    settle();
    base      = n_done;
    a_v[i]    = a;
    b_v[i]    = b;
    op_v[i]   = op;
    req_valid[i] = 1'b1;
    wait_acc(i, "accept");
    req_valid[i] = 1'b0;
    wait_done(base + 1, "done");
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: rnd_opnd = 32'h0000_0000;
      1: rnd_opnd = 32'h0000_0001;
      2: rnd_opnd = 32'h7FFF_FFFF;
      3: rnd_opnd = 32'h8000_0000;
      4: rnd_opnd = 32'hFFFF_FFFF;
      default: rnd_opnd = $urandom();
    endcase
  endfunction

  function automatic logic [3:0] rnd_op();
    case ($urandom_range(0, 4))
      0: rnd_op = 4'b0000;
      1: rnd_op = 4'b0010;
      2: rnd_op = 4'b1010;
      3: rnd_op = 4'b1010;
      default: rnd_op = 4'($urandom());
    endcase
  endfunction

  initial begin
    int base;
    int n;
    cyc       = 0;
    checks    = 0;
    failures  = 0;
    n_done    = 0;
    mptr      = 0;
    rst_n     = 1'b0;
    res_ready = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      a_v[i]  = '0;
      b_v[i]  = '0;
      op_v[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_res_valid", res_valid, 1'b0);
    check_eq("rst_res_data", res_data, 32'd0);
    check_eq("rst_res_id", res_id, 3'd0);
    check_eq("rst_res_err", res_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_req_ready", req_ready, 3'b000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin with two requesters held valid from reset.
    a_v[0] = 32'd10; b_v[0] = 32'd3; op_v[0] = 4'b0010;
    a_v[1] = 32'd1;  b_v[1] = 32'd1; op_v[1] = 4'b0000;
    res_ready = 1'b1;
    req_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      wait_done(k + 1, "rr_done");
      check_eq("rr_id", last_id, k % 2);
      check_eq("rr_data", last_data, (k % 2 == 1) ? 32'd2 : 32'd7);
    end
    #1;
    req_valid = '0;

    do_one(0, 32'd5, 32'd7, 4'b0000);
    check_eq("add_data", last_data, 32'd12);
    check_eq("add_id", last_id, 0);
    check_eq("add_err", last_err, 1'b0);

    do_one(1, 32'h8000_0000, 32'd1, 4'b1010);
    check_eq("slt_min", last_data, 32'd1);
    do_one(2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b1010);
    check_eq("slt_max", last_data, 32'd0);
    check_eq("slt_id", last_id, 2);

    // Illegal op from requester 0 must still move the pointer past it.
    do_one(0, 32'd3, 32'd4, 4'b0111);
    check_eq("ill_data", last_data, 32'd0);
    check_eq("ill_err", last_err, 1'b1);
    settle();
    req_valid = 3'b011;
    wait_acc(1, "ill_next_acc");
    check_eq("ill_next_grant", acc_mask, 3'b010);
    req_valid[1] = 1'b0;
    wait_acc(0, "ill_req0_acc");
    req_valid[0] = 1'b0;

    // Backpressure: result held for five cycles.
    settle();
    base = n_done;
    res_ready = 1'b0;
    a_v[2] = 32'd100; b_v[2] = 32'd1; op_v[2] = 4'b0010;
    req_valid[2] = 1'b1;
    wait_acc(2, "bp_acc");
    req_valid[2] = 1'b0;
    req_valid[0] = 1'b1;
    wait_resp_valid("bp_valid");
    repeat (5) @(posedge clk);
    #1;
    check_eq("bp_hold", n_done, base);
    check_eq("bp_no_ready", req_ready, 3'b000);
    res_ready = 1'b1;
    wait_done(base + 1, "bp_done");
    check_eq("bp_data", last_data, 32'd99);
    wait_acc(0, "bp_req0_acc");
    req_valid[0] = 1'b0;

    // Reset while a result is being held.
    do_one(0, 32'd1, 32'd2, 4'b0000);
    settle();
    res_ready = 1'b0;
    a_v[1] = 32'd55; b_v[1] = 32'd66; op_v[1] = 4'b0000;
    req_valid[1] = 1'b1;
    wait_acc(1, "mid_acc");
    req_valid[1] = 1'b0;
    wait_resp_valid("mid_valid");
    base = n_done;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", res_valid, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_data", res_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    req_valid = 3'b011;
    wait_acc(0, "mid_after_acc");
    check_eq("mid_ptr_zero", acc_mask, 3'b001);
    req_valid[0] = 1'b0;
    wait_acc(1, "mid_after_acc1");
    req_valid[1] = 1'b0;
    settle();
    check_eq("mid_dropped", n_done, base + 2);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          a_v[i]  = rnd_opnd();
          b_v[i]  = rnd_opnd();
          op_v[i] = rnd_op();
          req_valid[i] = 1'b1;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    n = 0;
    while (n < 300 && (req_valid != '0 || q.size() != 0)) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc_mask[i]) req_valid[i] = 1'b0;
      res_ready = 1'b1;
      n++;
    end
    check_eq("drain_empty", q.size() + $countones(req_valid), 0);
    check_eq("rand_progress", n_done > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
